run_ctrl: RTL and testbench
===========================

# run_ctrl

Sequencer that drives the `run` advance strobe and `mode` of the main training state machine (`state_main`). It watches the main state `q`, launches the matching compute engine (forward, forward-backward, last-backward, update), waits for that engine's `done`, then pulses `run` to advance the main FSM. It is the host-facing front end of the training datapath and holds a per-batch sample index for address generation.

## Interface
Parameters:
- `TIMEOUT_W`, 20: width of the per-stage watchdog counter. A stage times out after 2^TIMEOUT_W−1 cycles in WAIT.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. Shared with `state_main`.
- `start` in 1: host request to begin one run.
- `mode_in` in `MODE_LEN`: requested mode, sampled on an accepted start.
- `main_q` in `STATE_LEN`: current state of `state_main`.
- `done_ff`, `done_fb`, `done_lb`, `done_update` in 1 each: engine completion pulses.
- `run` out 1: advance strobe to `state_main`, one cycle per advance.
- `mode` out `MODE_LEN`: latched mode to `state_main`. Stable from accepted start through return to IDLE.
- `start_ff`, `start_fb`, `start_lb`, `start_update` out 1 each: one-cycle engine launch pulses.
- `busy` out 1: high in every state except IDLE.
- `finish` out 1: one-cycle pulse when the FIN advance is issued.
- `err` out 1: sticky error flag, cleared by the next accepted start.
- `batch_idx` out 8: count of completed FF/FB stages in the current run.

## Operation
- All outputs are registered. Reset value of every output and every counter is 0; the state resets to IDLE.
- States: IDLE, ADV, LAUNCH, WAIT, DRAIN.
- **IDLE**
  - `start` is accepted only when `main_q`==`M_IDLE`. On accept: latch `mode`<=`mode_in`, clear `err` and `batch_idx`, assert `run`, go to ADV.
  - `start` that is not accepted (busy, or `main_q`≠`M_IDLE`) is dropped with no other effect.
- **ADV**: deassert `run`, go to LAUNCH. This state absorbs the update of `main_q`.
- **LAUNCH**: decode `main_q`.
  - `M_FF`, `M_FB`, `M_LB` or `M_UPDATE`: pulse the matching `start_*`, clear the watchdog, go to WAIT. Record which stage was launched.
  - `M_FIN`: assert `run` and `finish`, go to DRAIN.
  - Any other value (including `M_IDLE` or X): set `err`, go to IDLE with no `run`.
- **WAIT**
  - When the `done_*` for the recorded stage is sampled high: assert `run` and go to ADV. If the stage is FF or FB, also increment `batch_idx`, saturating at 255.
  - `done_*` of a stage other than the launched one is ignored.
  - The watchdog increments every WAIT cycle. On reaching all-ones: set `err`, go to IDLE with no `run`. `state_main` is left as-is; the host must reset.
- **DRAIN**: deassert `run` and `finish`, go to IDLE.
- Only one `start_*` is high at any time. At most one `run` is issued per launched stage.

## Timing
- `start` sampled at edge E0 → `run`=1 during E0–E1 → `state_main` updates at E1 → LAUNCH samples `main_q` at E2 → `start_*`=1 during E2–E3.
- `done_*` sampled at edge Ek → `run`=1 during Ek–Ek+1 → next `start_*` at Ek+2. Done-to-next-launch latency is 2 cycles.
- A `done` that is high in the LAUNCH cycle is not observed. Engines must not assert `done` earlier than the cycle after `start_*`.
- If `start` and `done_*` occur in the same cycle while busy, `start` is dropped and `done_*` is handled.
- Asserting `rst_n` low mid-run returns all state and outputs to 0/IDLE immediately, together with `state_main`.

## Structure
- `M_*` state codes, `STATE_LEN`, `MODE_LEN`, `TRAIN` and `BATCH_SIZE` come from `consts_train.vh`.
- Add the controller codes `C_IDLE`, `C_ADV`, `C_LAUNCH`, `C_WAIT`, `C_DRAIN` and their width `C_STATE_LEN` to the same include.
- One sub-module: `watchdog`, a clearable saturating counter of width `TIMEOUT_W` with an all-ones flag.

## Test plan
Bench setup: `run_ctrl` connected to a real `state_main` with `BATCH_SIZE`=4; engine models assert `done` 3 cycles after `start_*`.
- **Inference**: `mode_in`≠`TRAIN`, pulse `start` → exactly 4 `start_ff`, one `finish`, `batch_idx`=4, `busy` falls 1 cycle after `finish`, `main_q` returns to `M_IDLE`.
- **Train**: `mode_in`=`TRAIN` → launch order is 1 `start_ff`, 3 `start_fb`, 1 `start_lb`, 1 `start_update`, then `finish`; final `batch_idx`=4.
- **Cycle latency**: check `run` 1 cycle after `start`, `start_ff` 2 cycles after `run`, and `run` 1 cycle after each `done`.
- **Robustness**: re-pulse `start` while busy, and inject a `done_lb` during FF WAIT → both ignored; launch sequence identical to the train case.
- **Watchdog**: with `TIMEOUT_W`=4, withhold `done_fb` → `err`=1 after 15 WAIT cycles, `busy`=0, no extra `run`; the next accepted `start` clears `err`.
- **Reset mid-run**: drop `rst_n` during an FB WAIT → all outputs 0 asynchronously; a new `start` after release completes a normal train run.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared constants and types for the training run controller and its bench.
// The main-FSM codes mirror the training include so both sides decode the same values.
package run_ctrl_pkg;

    localparam int STATE_LEN  = 3;
    localparam int MODE_LEN   = 2;
    localparam int BATCH_SIZE = 4;

    localparam logic [MODE_LEN-1:0] TRAIN = 2'd1;

    localparam logic [STATE_LEN-1:0] M_IDLE   = 3'd0;
    localparam logic [STATE_LEN-1:0] M_FF     = 3'd1;
    localparam logic [STATE_LEN-1:0] M_FB     = 3'd2;
    localparam logic [STATE_LEN-1:0] M_LB     = 3'd3;
    localparam logic [STATE_LEN-1:0] M_UPDATE = 3'd4;
    localparam logic [STATE_LEN-1:0] M_FIN    = 3'd5;

    localparam int C_STATE_LEN = 3;

    typedef enum logic [C_STATE_LEN-1:0] {
        C_IDLE   = 3'd0,
        C_ADV    = 3'd1,
        C_LAUNCH = 3'd2,
        C_WAIT   = 3'd3,
        C_DRAIN  = 3'd4
    } ctrl_state_t;

    typedef enum logic [1:0] {
        STG_FF     = 2'd0,
        STG_FB     = 2'd1,
        STG_LB     = 2'd2,
        STG_UPDATE = 2'd3
    } stage_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Host/engine/main-FSM handshake bundle of the run controller.
interface run_ctrl_if;
    import run_ctrl_pkg::*;

    logic                 start;
    logic [MODE_LEN-1:0]  mode_in;
    logic [STATE_LEN-1:0] main_q;
    logic                 done_ff;
    logic                 done_fb;
    logic                 done_lb;
    logic                 done_update;
    logic                 run;
    logic [MODE_LEN-1:0]  mode;
    logic                 start_ff;
    logic                 start_fb;
    logic                 start_lb;
    logic                 start_update;
    logic                 busy;
    logic                 finish;
    logic                 err;
    logic [7:0]           batch_idx;

    modport master (
        output start, mode_in, main_q, done_ff, done_fb, done_lb, done_update,
        input  run, mode, start_ff, start_fb, start_lb, start_update,
               busy, finish, err, batch_idx
    );

    modport slave (
        input  start, mode_in, main_q, done_ff, done_fb, done_lb, done_update,
        output run, mode, start_ff, start_fb, start_lb, start_update,
               busy, finish, err, batch_idx
    );

endinterface

// File: rtl/run_ctrl_watchdog.sv
// Clearable saturating cycle counter; o_full flags that the count reaches all-ones this cycle.
module run_ctrl_watchdog #(
    parameter int W = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_full
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_en && (r_cnt != ALL_ONES)) begin
            w_cnt_nxt = r_cnt + ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Flag on the next value so the stage expires at the end of its last allowed cycle.
    assign o_full = (w_cnt_nxt == ALL_ONES);

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: launches the engine matching the main FSM state, waits for its done,
// then pulses run to advance the main FSM. All outputs come straight from registers.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 20
) (
    input  logic      clk,
    input  logic      rst_n,
    run_ctrl_if.slave bus
);

    ctrl_state_t         r_state, w_state_nxt;
    stage_t              r_stage, w_stage_nxt;
    logic                r_run, w_run_nxt;
    logic                r_finish, w_finish_nxt;
    logic                r_err, w_err_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_start_ff, w_start_ff_nxt;
    logic                r_start_fb, w_start_fb_nxt;
    logic                r_start_lb, w_start_lb_nxt;
    logic                r_start_up, w_start_up_nxt;
    logic [MODE_LEN-1:0] r_mode, w_mode_nxt;
    logic [7:0]          r_batch_idx, w_batch_nxt;
    logic                w_wd_clr, w_wd_en, w_wd_full, w_done_sel;

    run_ctrl_watchdog #(.W(TIMEOUT_W)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_wd_clr),
        .i_en   (w_wd_en),
        .o_full (w_wd_full)
    );

    // Only the done of the stage actually launched may advance the sequence.
    always_comb begin
        w_done_sel = 1'b0;
        case (r_stage)
            STG_FF:     w_done_sel = bus.done_ff;
            STG_FB:     w_done_sel = bus.done_fb;
            STG_LB:     w_done_sel = bus.done_lb;
            STG_UPDATE: w_done_sel = bus.done_update;
            default:    w_done_sel = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_stage_nxt    = r_stage;
        w_run_nxt      = 1'b0;
        w_finish_nxt   = 1'b0;
        w_err_nxt      = r_err;
        w_mode_nxt     = r_mode;
        w_batch_nxt    = r_batch_idx;
        w_start_ff_nxt = 1'b0;
        w_start_fb_nxt = 1'b0;
        w_start_lb_nxt = 1'b0;
        w_start_up_nxt = 1'b0;
        w_wd_clr       = 1'b0;
        w_wd_en        = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (bus.start && (bus.main_q == M_IDLE)) begin
                    w_mode_nxt  = bus.mode_in;
                    w_err_nxt   = 1'b0;
                    w_batch_nxt = 8'd0;
                    w_run_nxt   = 1'b1;
                    w_state_nxt = C_ADV;
                end else begin
                    w_state_nxt = C_IDLE;
                end
            end
            C_ADV: begin
                w_state_nxt = C_LAUNCH;
            end
            C_LAUNCH: begin
                w_wd_clr    = 1'b1;
                w_state_nxt = C_WAIT;
                case (bus.main_q)
                    M_FF: begin
                        w_start_ff_nxt = 1'b1;
                        w_stage_nxt    = STG_FF;
                    end
                    M_FB: begin
                        w_start_fb_nxt = 1'b1;
                        w_stage_nxt    = STG_FB;
                    end
                    M_LB: begin
                        w_start_lb_nxt = 1'b1;
                        w_stage_nxt    = STG_LB;
                    end
                    M_UPDATE: begin
                        w_start_up_nxt = 1'b1;
                        w_stage_nxt    = STG_UPDATE;
                    end
                    M_FIN: begin
                        w_run_nxt    = 1'b1;
                        w_finish_nxt = 1'b1;
                        w_state_nxt  = C_DRAIN;
                    end
                    default: begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = C_IDLE;
                    end
                endcase
            end
            C_WAIT: begin
                w_wd_en = 1'b1;
                if (w_done_sel) begin
                    w_run_nxt   = 1'b1;
                    w_state_nxt = C_ADV;
                    if ((r_stage == STG_FF) || (r_stage == STG_FB)) begin
                        w_batch_nxt = sat_inc8(r_batch_idx);
                    end else begin
                        w_batch_nxt = r_batch_idx;
                    end
                end else if (w_wd_full) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = C_IDLE;
                end else begin
                    w_state_nxt = C_WAIT;
                end
            end
            C_DRAIN: begin
                w_state_nxt = C_IDLE;
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != C_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= C_IDLE;
            r_stage     <= STG_FF;
            r_run       <= 1'b0;
            r_finish    <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_start_ff  <= 1'b0;
            r_start_fb  <= 1'b0;
            r_start_lb  <= 1'b0;
            r_start_up  <= 1'b0;
            r_mode      <= '0;
            r_batch_idx <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_stage     <= w_stage_nxt;
            r_run       <= w_run_nxt;
            r_finish    <= w_finish_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_start_ff  <= w_start_ff_nxt;
            r_start_fb  <= w_start_fb_nxt;
            r_start_lb  <= w_start_lb_nxt;
            r_start_up  <= w_start_up_nxt;
            r_mode      <= w_mode_nxt;
            r_batch_idx <= w_batch_nxt;
        end
    end

    assign bus.run          = r_run;
    assign bus.finish       = r_finish;
    assign bus.err          = r_err;
    assign bus.busy         = r_busy;
    assign bus.start_ff     = r_start_ff;
    assign bus.start_fb     = r_start_fb;
    assign bus.start_lb     = r_start_lb;
    assign bus.start_update = r_start_up;
    assign bus.mode         = r_mode;
    assign bus.batch_idx    = r_batch_idx;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: behavioural main-FSM and engine models, table-driven and random runs,
// plus watchdog and mid-run reset sequences.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    run_ctrl_if bus();

    run_ctrl #(.TIMEOUT_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural state_main: advances on run; counts forward samples of the batch.
    logic [STATE_LEN-1:0] sm_q;
    int                   sm_n;
    logic                 sm_clr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_q <= M_IDLE;
            sm_n <= 0;
        end else if (sm_clr) begin
            sm_q <= M_IDLE;
            sm_n <= 0;
        end else if (bus.run) begin
            case (sm_q)
                M_IDLE: begin sm_q <= M_FF; sm_n <= 1; end
                M_FF, M_FB: begin
                    if (sm_n < BATCH_SIZE) begin
                        sm_q <= (bus.mode == TRAIN) ? M_FB : M_FF;
                        sm_n <= sm_n + 1;
                    end else begin
                        sm_q <= (bus.mode == TRAIN) ? M_LB : M_FIN;
                    end
                end
                M_LB:     sm_q <= M_UPDATE;
                M_UPDATE: sm_q <= M_FIN;
                M_FIN:    sm_q <= M_IDLE;
                default:  sm_q <= M_IDLE;
            endcase
        end
    end
    assign bus.main_q = sm_q;

    // Engine model: done pulses eng_lat cycles after a start_* pulse.
    int   eng_lat;
    int   eng_cnt;
    int   eng_id;
    logic eng_act;
    logic hold_fb;
    logic inj_lb;
    logic eng_fire;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_act <= 1'b0;
            eng_cnt <= 0;
            eng_id  <= 0;
        end else if (bus.start_ff | bus.start_fb | bus.start_lb | bus.start_update) begin
            eng_act <= 1'b1;
            eng_cnt <= eng_lat;
            eng_id  <= bus.start_ff ? 0 : bus.start_fb ? 1 : bus.start_lb ? 2 : 3;
        end else if (eng_act) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) eng_act <= 1'b0;
        end
    end
    assign eng_fire        = eng_act && (eng_cnt == 1);
    assign bus.done_ff     = eng_fire && (eng_id == 0);
    assign bus.done_fb     = eng_fire && (eng_id == 1) && !hold_fb;
    assign bus.done_lb     = (eng_fire && (eng_id == 2)) || inj_lb;
    assign bus.done_update = eng_fire && (eng_id == 3);

    // Monitor: launch log, run/finish counts, done->run latency and one-hot launch checks.
    int   lg[$];
    int   run_cnt = 0;
    int   fin_cnt = 0;
    int   lat_viol = 0;
    int   multi_viol = 0;
    logic prev_done = 1'b0;
    logic d_gen;
    assign d_gen = bus.done_ff | bus.done_fb | (eng_fire && (eng_id == 2)) | bus.done_update;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.start_ff)     lg.push_back(0);
            if (bus.start_fb)     lg.push_back(1);
            if (bus.start_lb)     lg.push_back(2);
            if (bus.start_update) lg.push_back(3);
            if (bus.run)    run_cnt <= run_cnt + 1;
            if (bus.finish) fin_cnt <= fin_cnt + 1;
            if (prev_done && !bus.run) lat_viol <= lat_viol + 1;
            if ((32'(bus.start_ff) + 32'(bus.start_fb) + 32'(bus.start_lb) + 32'(bus.start_update)) > 1)
                multi_viol <= multi_viol + 1;
            prev_done <= d_gen;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_one(input logic [1:0] m, input int lat, input bit disturb,
                           input int e_ff, input int e_fb, input int e_lb, input int e_up, input int e_bi);
        int cyc;
        int b_lg, b_run, b_fin, b_lv, b_mv;
        int cnt[4];
        int exp_q[$];
        bit ord_ok;
        eng_lat = lat;
        if (m == TRAIN) begin
            exp_q.push_back(0);
            repeat (BATCH_SIZE - 1) exp_q.push_back(1);
            exp_q.push_back(2);
            exp_q.push_back(3);
        end else begin
            repeat (BATCH_SIZE) exp_q.push_back(0);
        end
        @(negedge clk);
        b_lg = lg.size(); b_run = run_cnt; b_fin = fin_cnt; b_lv = lat_viol; b_mv = multi_viol;
        bus.mode_in = m;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("run_after_start", bus.run, 1);
        check("err_cleared", bus.err, 0);
        check("mode_latched", bus.mode, m);
        cyc = 0;
        while (bus.start_ff !== 1'b1 && cyc < 10) begin @(negedge clk); cyc++; end
        check("ff_after_run", cyc, 2);
        if (disturb) begin
            @(negedge clk);
            inj_lb    = 1'b1;
            bus.start = 1'b1;
            @(negedge clk);
            inj_lb    = 1'b0;
            bus.start = 1'b0;
        end
        cyc = 0;
        while (bus.finish !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
        check("finish_seen", bus.finish, 1);
        check("busy_at_finish", bus.busy, 1);
        check("mode_stable", bus.mode, m);
        @(negedge clk);
        check("busy_fall", bus.busy, 0);
        check("finish_pulse", bus.finish, 0);
        repeat (2) @(negedge clk);
        cnt = '{0, 0, 0, 0};
        for (int i = b_lg; i < lg.size(); i++) cnt[lg[i]]++;
        ord_ok = ((lg.size() - b_lg) == exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (ord_ok && (lg[b_lg + i] != exp_q[i])) ord_ok = 1'b0;
        check("n_start_ff", cnt[0], e_ff);
        check("n_start_fb", cnt[1], e_fb);
        check("n_start_lb", cnt[2], e_lb);
        check("n_start_update", cnt[3], e_up);
        check("launch_order", ord_ok, 1);
        check("batch_idx", bus.batch_idx, e_bi);
        check("main_q_idle", bus.main_q, M_IDLE);
        check("err_clean", bus.err, 0);
        check("n_finish", fin_cnt - b_fin, 1);
        check("n_run", run_cnt - b_run, e_ff + e_fb + e_lb + e_up + 2);
        check("done_to_run", lat_viol - b_lv, 0);
        check("one_hot_start", multi_viol - b_mv, 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        int         lat;
        bit         disturb;
        int         e_ff, e_fb, e_lb, e_up, e_bi;
    } vec_t;

    vec_t tbl[5];
    int   rb;
    int   cyc;

    initial begin
        tbl[0] = '{2'd0, 3, 1'b0, 4, 0, 0, 0, 4};
        tbl[1] = '{2'd1, 3, 1'b0, 1, 3, 1, 1, 4};
        tbl[2] = '{2'd1, 3, 1'b1, 1, 3, 1, 1, 4};
        tbl[3] = '{2'd2, 1, 1'b0, 4, 0, 0, 0, 4};
        tbl[4] = '{2'd3, 5, 1'b1, 4, 0, 0, 0, 4};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.mode_in = 2'd0;
        sm_clr      = 1'b0;
        hold_fb     = 1'b0;
        inj_lb      = 1'b0;
        eng_lat     = 3;
        #1;
        check("rst_run", bus.run, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_batch", bus.batch_idx, 0);
        check("rst_mode", bus.mode, 0);
        check("rst_finish", bus.finish, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_one(tbl[i].mode, tbl[i].lat, tbl[i].disturb,
                    tbl[i].e_ff, tbl[i].e_fb, tbl[i].e_lb, tbl[i].e_up, tbl[i].e_bi);

        for (int i = 0; i < 6; i++) begin
            logic [1:0] rm;
            int         rl;
            rm = 2'($urandom_range(0, 3));
            rl = int'($urandom_range(1, 6));
            if (rm == TRAIN) run_one(rm, rl, 1'b0, 1, BATCH_SIZE - 1, 1, 1, BATCH_SIZE);
            else             run_one(rm, rl, 1'b0, BATCH_SIZE, 0, 0, 0, BATCH_SIZE);
        end

        // Watchdog: the FB engine never answers.
        hold_fb = 1'b1;
        eng_lat = 3;
        @(negedge clk);
        bus.mode_in = TRAIN;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.start_fb !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        check("wd_fb_launch", bus.start_fb, 1);
        rb = run_cnt;
        repeat (14) @(negedge clk);
        check("wd_err_before", bus.err, 0);
        check("wd_busy_before", bus.busy, 1);
        @(negedge clk);
        check("wd_err_set", bus.err, 1);
        check("wd_busy_clear", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("wd_no_run", run_cnt - rb, 0);
        check("wd_main_q_held", bus.main_q, M_FB);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("wd_start_dropped", bus.run, 0);
        check("wd_err_sticky", bus.err, 1);
        sm_clr = 1'b1;
        @(negedge clk);
        sm_clr  = 1'b0;
        hold_fb = 1'b0;
        run_one(TRAIN, 3, 1'b0, 1, 3, 1, 1, 4);

        // Reset in the middle of an FB wait.
        @(negedge clk);
        bus.mode_in = TRAIN;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.start_fb !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        check("mid_busy", bus.busy, 1);
        check("mid_batch", bus.batch_idx, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_run", bus.run, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_mode", bus.mode, 0);
        check("arst_batch", bus.batch_idx, 0);
        check("arst_err_fin", {bus.err, bus.finish}, 0);
        check("arst_starts", {bus.start_ff, bus.start_fb, bus.start_lb, bus.start_update}, 0);
        check("arst_main_q", bus.main_q, M_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        run_one(TRAIN, 3, 1'b0, 1, 3, 1, 1, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
